pit8253_master: RTL and testbench
=================================

PIT8253_MASTER -- requirements
Module: pit8253_master

Interface
REQ-001 SHALL have: clk  in  1  system clock, single clock domain.
REQ-002 SHALL have: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: ce  in  1  bus clock enable; one PIT bus access per ce period.
REQ-004 SHALL have: cmd_valid  in  1 / cmd_ready  out  1  command handshake.
REQ-005 SHALL have: cmd_op  in  1  0=LOAD, 1=READ (latched count).
REQ-006 SHALL have: cmd_ch  in  2  counter 0..2; 3 is illegal.
REQ-007 SHALL have: cmd_rl  in  2, cmd_mode  in  3, cmd_bcd  in  1  control-word fields.
REQ-008 SHALL have: cmd_count  in  16  load value.
REQ-009 SHALL have: rsp_valid  out  1, rsp_err  out  1, rsp_data  out  16  completion.
REQ-010 SHALL have: pit_a  out  2, pit_wr  out  1, pit_rd  out  1, pit_dout  out  8, pit_din  in  8  PIT bus.
REQ-011 SHALL have: busy  out  1  high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, CW, WLO, WHI, RLO, RHI, DONE.
REQ-013 cmd_ready SHALL be 1 only in IDLE, independent of ce; the command is captured on the clk edge with cmd_valid&cmd_ready.
REQ-014 Bus outputs SHALL be registered, change only on ce=1 edges, and be held one full ce period, so the PIT samples each strobe on exactly one ce=1 cycle.
REQ-015 pit_wr and pit_rd SHALL never be high together; pit_a/pit_dout SHALL be stable while a strobe is high.
REQ-016 LOAD SHALL issue CW write: pit_a=3, pit_dout={ch,rl,mode,bcd}.
REQ-017 LOAD then SHALL write to pit_a=ch: rl=01 LSB only; rl=10 MSB only; rl=11 LSB then MSB.
REQ-018 LOAD with rl=00 SHALL perform no bus access and complete with rsp_err=1.
REQ-019 READ SHALL write the latch command pit_a=3, pit_dout={ch,6'b000000}, then read pit_a=ch twice: LSB, then MSB.
REQ-020 Read data SHALL be captured from pit_din on the ce=1 cycle on which pit_rd is sampled high.
REQ-021 Any command with ch=3 SHALL complete with rsp_err=1 and no bus access.
REQ-022 DONE SHALL pulse rsp_valid for exactly one clk, then return to IDLE on the next clk.
REQ-023 rsp_data SHALL be {MSB,LSB} for READ and 16'h0000 for LOAD or error; rsp_err SHALL be 0 on success.
REQ-024 With ce held 1, acceptance-to-rsp_valid SHALL be 4 clk for LOAD rl=11, 3 for rl=01/10, 4 for READ, and 1 for error.
REQ-025 ce=0 cycles SHALL stall the FSM without altering the bus outputs.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately force IDLE, pit_wr=pit_rd=0, pit_a=0, pit_dout=0, rsp_valid=rsp_err=0, rsp_data=0, and busy=0.
REQ-027 A reset during an access SHALL abort it; no strobe SHALL appear after release until a new command is accepted.
REQ-028 cmd_ready SHALL be 1 on the first clk after reset_n rises.

Configuration
REQ-029 Macro PIT8253_MASTER_READBACK_EN defined: READ SHALL behave per REQ-019/020.
REQ-030 Macro PIT8253_MASTER_READBACK_EN undefined: READ SHALL complete as an error per REQ-021 with no bus access, and the RLO/RHI logic SHALL be absent.

Verification
REQ-031 LOAD ch=0 rl=11 mode=3 bcd=0 count=16'h1234, ce=1 -> bus writes (3,0x36), (0,0x34), (0,0x12); one rsp_valid, rsp_err=0.
REQ-032 LOAD ch=2 rl=01 count=16'h00AB, ce every 4th clk -> writes (3,0x90), (2,0xAB); each strobe held 4 clk; rsp after the 3rd ce pulse.
REQ-033 READ ch=1 with a PIT model holding 16'hBEEF -> write (3,0x40), reads at a=1 return EF then BE; rsp_data=16'hBEEF.
REQ-034 LOAD ch=3 or rl=00 -> no pit_wr/pit_rd; rsp_valid with rsp_err=1 one clk after acceptance.
REQ-035 reset_n low during WHI -> all outputs 0 in the same cycle; after release no strobe, cmd_ready=1.
REQ-036 Without PIT8253_MASTER_READBACK_EN, READ ch=0 -> no bus activity, rsp_err=1.

Source files
------------

// File: rtl/pit8253_master.sv
// pit8253_master: command-driven bus master for an 8253-style interval timer.
// Executes LOAD (control word + count bytes) and READ (latch + two byte reads)
// over a ce-paced PIT bus, then reports completion on the rsp_* outputs.
// Optional feature macro: PIT8253_MASTER_READBACK_EN enables the READ path;
// without it a READ completes immediately as an error and the RLO/RHI states
// and read-data capture do not exist.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// CW    | control-word / latch-command write on the bus
// WLO   | count LSB write on the bus
// WHI   | count MSB write on the bus
// RLO   | latched LSB read on the bus (readback build only)
// RHI   | latched MSB read on the bus (readback build only)
// DONE  | one-clk completion pulse on rsp_valid
module pit8253_master (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_ch,
    input  logic [1:0]  cmd_rl,
    input  logic [2:0]  cmd_mode,
    input  logic        cmd_bcd,
    input  logic [15:0] cmd_count,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic [1:0]  pit_a,
    output logic        pit_wr,
    output logic        pit_rd,
    output logic [7:0]  pit_dout,
    input  logic [7:0]  pit_din,
    output logic        busy
);

`ifdef PIT8253_MASTER_READBACK_EN
    typedef enum logic [2:0] {IDLE, CW, WLO, WHI, RLO, RHI, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, CW, WLO, WHI, DONE} state_t;
`endif

    state_t      state_q, state_d, nxt_s;
    // issued_q: the strobe belonging to the current state is already on the bus
    logic        issued_q, issued_d;
    logic        op_q, op_d;
    logic [1:0]  ch_q, ch_d;
    logic [1:0]  rl_q, rl_d;
    logic [2:0]  mode_q, mode_d;
    logic        bcd_q, bcd_d;
    logic [15:0] count_q, count_d;
    logic        pit_wr_q, pit_wr_d;
    logic        pit_rd_q, pit_rd_d;
    logic [1:0]  pit_a_q, pit_a_d;
    logic [7:0]  pit_dout_q, pit_dout_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] rsp_data_q, rsp_data_d;
`ifdef PIT8253_MASTER_READBACK_EN
    logic [7:0]  lsb_q, lsb_d;
`else
    logic        unused_din;
    assign unused_din = ^pit_din;
`endif

    // Bus image {wr, rd, a, dout} presented while the FSM sits in state s.
    function automatic logic [11:0] bus_for(input state_t s, input logic op,
                                            input logic [1:0] ch, input logic [1:0] rl,
                                            input logic [2:0] mode, input logic bcd,
                                            input logic [15:0] count);
        logic [11:0] b;
        b = 12'h000;
        case (s)
            CW:      b = {2'b10, 2'd3, (op ? {ch, 6'b000000} : {ch, rl, mode, bcd})};
            WLO:     b = {2'b10, ch, count[7:0]};
            WHI:     b = {2'b10, ch, count[15:8]};
`ifdef PIT8253_MASTER_READBACK_EN
            RLO,
            RHI:     b = {2'b01, ch, 8'h00};
`endif
            default: b = 12'h000;
        endcase
        return b;
    endfunction

    // State, captured command, registered bus and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            issued_q    <= 1'b0;
            op_q        <= 1'b0;
            ch_q        <= 2'd0;
            rl_q        <= 2'd0;
            mode_q      <= 3'd0;
            bcd_q       <= 1'b0;
            count_q     <= 16'h0000;
            pit_wr_q    <= 1'b0;
            pit_rd_q    <= 1'b0;
            pit_a_q     <= 2'd0;
            pit_dout_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 16'h0000;
`ifdef PIT8253_MASTER_READBACK_EN
            lsb_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            op_q        <= op_d;
            ch_q        <= ch_d;
            rl_q        <= rl_d;
            mode_q      <= mode_d;
            bcd_q       <= bcd_d;
            count_q     <= count_d;
            pit_wr_q    <= pit_wr_d;
            pit_rd_q    <= pit_rd_d;
            pit_a_q     <= pit_a_d;
            pit_dout_q  <= pit_dout_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
`ifdef PIT8253_MASTER_READBACK_EN
            lsb_q       <= lsb_d;
`endif
        end
    end

    // Next-state, command capture and bus sequencing; bus only moves when ce=1.
    always_comb begin
        state_d     = state_q;
        nxt_s       = state_q;
        issued_d    = issued_q;
        op_d        = op_q;
        ch_d        = ch_q;
        rl_d        = rl_q;
        mode_d      = mode_q;
        bcd_d       = bcd_q;
        count_d     = count_q;
        {pit_wr_d, pit_rd_d, pit_a_d, pit_dout_d} = {pit_wr_q, pit_rd_q, pit_a_q, pit_dout_q};
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = 16'h0000;
`ifdef PIT8253_MASTER_READBACK_EN
        lsb_d       = lsb_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    ch_d    = cmd_ch;
                    rl_d    = cmd_rl;
                    mode_d  = cmd_mode;
                    bcd_d   = cmd_bcd;
                    count_d = cmd_count;
                    if ((cmd_ch == 2'd3) || (!cmd_op && (cmd_rl == 2'b00))
`ifndef PIT8253_MASTER_READBACK_EN
                        || cmd_op
`endif
                       ) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = CW;
                        // Accepting on a ce cycle puts the first strobe out immediately.
                        issued_d = ce;
                        if (ce) begin
                            {pit_wr_d, pit_rd_d, pit_a_d, pit_dout_d} =
                                bus_for(CW, cmd_op, cmd_ch, cmd_rl, cmd_mode, cmd_bcd, cmd_count);
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (ce) begin
                    if (!issued_q) begin
                        issued_d = 1'b1;
                        {pit_wr_d, pit_rd_d, pit_a_d, pit_dout_d} =
                            bus_for(state_q, op_q, ch_q, rl_q, mode_q, bcd_q, count_q);
                    end else begin
                        case (state_q)
                            CW: begin
`ifdef PIT8253_MASTER_READBACK_EN
                                if (op_q)
                                    nxt_s = RLO;
                                else
`endif
                                nxt_s = (rl_q == 2'b10) ? WHI : WLO;
                            end
                            WLO: nxt_s = (rl_q == 2'b11) ? WHI : DONE;
`ifdef PIT8253_MASTER_READBACK_EN
                            RLO: begin
                                nxt_s = RHI;
                                lsb_d = pit_din;
                            end
`endif
                            default: nxt_s = DONE;
                        endcase
                        state_d = nxt_s;
                        {pit_wr_d, pit_rd_d, pit_a_d, pit_dout_d} =
                            bus_for(nxt_s, op_q, ch_q, rl_q, mode_q, bcd_q, count_q);
                        if (nxt_s == DONE) begin
                            rsp_valid_d = 1'b1;
`ifdef PIT8253_MASTER_READBACK_EN
                            // MSB is sampled on the same ce edge that leaves RHI.
                            rsp_data_d  = op_q ? {pit_din, lsb_q} : 16'h0000;
`endif
                        end
                    end
                end
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign pit_wr    = pit_wr_q;
    assign pit_rd    = pit_rd_q;
    assign pit_a     = pit_a_q;
    assign pit_dout  = pit_dout_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_pit8253_master.sv
// Testbench for pit8253_master: directed and random commands checked against a
// transaction-level expectation plus a small behavioural PIT device model.
module tb_pit8253_master;

    logic        clk = 1'b0;
    logic        reset_n, ce, cmd_valid, cmd_ready, cmd_op, cmd_bcd;
    logic [1:0]  cmd_ch, cmd_rl;
    logic [2:0]  cmd_mode;
    logic [15:0] cmd_count;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_data;
    logic [1:0]  pit_a;
    logic        pit_wr, pit_rd;
    logic [7:0]  pit_dout, pit_din;
    logic        busy;

`ifdef PIT8253_MASTER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef logic [11:0] tx_t;

    int   total = 0;
    int   bad = 0;
    int   ce_mode = 0;
    int   viol = 0;
    int   wr_hi = 0;
    int   last_cep = 0;
    int   last_wr_hi = 0;
    tx_t  txq[$];

    logic [15:0] cnt   [4];
    logic [15:0] latch [4];
    logic        ptr   [4];

    pit8253_master dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ch(cmd_ch), .cmd_rl(cmd_rl), .cmd_mode(cmd_mode), .cmd_bcd(cmd_bcd),
        .cmd_count(cmd_count),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .pit_a(pit_a), .pit_wr(pit_wr), .pit_rd(pit_rd),
        .pit_dout(pit_dout), .pit_din(pit_din), .busy(busy)
    );

    always #5 clk = ~clk;

    // ce pacing: 0 = always on, 1 = every 4th clk, 2 = random
    initial begin
        int div;
        div = 0;
        ce = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            case (ce_mode)
                0:       ce = 1'b1;
                1:       ce = (div == 0);
                default: ce = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // PIT device model: latch command snapshots a counter, reads return LSB then MSB.
    always @(posedge clk) begin
        if (reset_n && ce) begin
            if (pit_wr && pit_a == 2'd3 && pit_dout[5:4] == 2'b00) begin
                latch[pit_dout[7:6]] <= cnt[pit_dout[7:6]];
                ptr[pit_dout[7:6]]   <= 1'b0;
            end
            if (pit_rd)
                ptr[pit_a] <= ~ptr[pit_a];
        end
    end

    always_comb pit_din = ptr[pit_a] ? latch[pit_a][15:8] : latch[pit_a][7:0];

    // Bus monitor: records each strobe the PIT samples and checks bus rules.
    initial begin
        logic [11:0] prev_bus;
        logic        prev_ce;
        bit          prev_ok;
        prev_ok = 0;
        prev_bus = '0;
        prev_ce = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) prev_ok = 0;
            else begin
                if (pit_wr && pit_rd) viol++;
                if (prev_ok && ({pit_wr, pit_rd, pit_a, pit_dout} != prev_bus) && !prev_ce) viol++;
                if (ce && (pit_wr || pit_rd))
                    txq.push_back({pit_wr, pit_rd, pit_a, (pit_wr ? pit_dout : pit_din)});
                if (pit_wr) wr_hi++;
                prev_bus = {pit_wr, pit_rd, pit_a, pit_dout};
                prev_ce  = ce;
                prev_ok  = 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic op, input logic [1:0] ch, input logic [1:0] rl,
                          input logic [2:0] mode, input logic bcd, input logic [15:0] count,
                          input int cm, input string tag);
        tx_t         exp_q[$];
        logic        exp_err;
        logic [15:0] exp_data, v;
        int          lat, cep;
        ce_mode = cm;
        repeat (2) @(negedge clk);
        exp_err  = (ch == 2'd3) || (!op && rl == 2'b00) || (op && !RB);
        exp_data = 16'h0000;
        if (!exp_err) begin
            if (!op) begin
                exp_q.push_back({2'b10, 2'd3, ch, rl, mode, bcd});
                if (rl[0]) exp_q.push_back({2'b10, ch, count[7:0]});
                if (rl[1]) exp_q.push_back({2'b10, ch, count[15:8]});
            end else begin
                v = cnt[ch];
                exp_q.push_back({2'b10, 2'd3, ch, 6'b000000});
                exp_q.push_back({2'b01, ch, v[7:0]});
                exp_q.push_back({2'b01, ch, v[15:8]});
                exp_data = v;
            end
        end
        txq.delete();
        wr_hi = 0;
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_ch = ch; cmd_rl = rl; cmd_mode = mode; cmd_bcd = bcd; cmd_count = count;
        cmd_valid = 1'b1;
        cep = int'(ce);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            cep += int'(ce);
            @(negedge clk);
            lat++;
        end
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (exp_err || cm == 0) chk({tag, " latency"}, 32'(lat), 32'(1 + exp_q.size()));
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, " n_tx"}, 32'(txq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s tx%0d", tag, i), (i < txq.size()) ? 32'(txq[i]) : 32'hxxxxxxxx,
                32'(exp_q[i]));
        last_cep = cep;
        last_wr_hi = wr_hi;
        @(negedge clk);
        chk({tag, " pulse_end"}, 32'(rsp_valid), 32'd0);
        chk({tag, " back_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 16'($urandom);
            latch[i] = 16'h0000;
            ptr[i] = 1'b0;
        end
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_ch = 2'd0; cmd_rl = 2'd0;
        cmd_mode = 3'd0; cmd_bcd = 1'b0; cmd_count = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset wr", 32'(pit_wr), 32'd0);
        chk("reset rd", 32'(pit_rd), 32'd0);
        chk("reset a", 32'(pit_a), 32'd0);
        chk("reset dout", 32'(pit_dout), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset rsp_data", 32'(rsp_data), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("post-reset ready", 32'(cmd_ready), 32'd1);

        do_cmd(1'b0, 2'd0, 2'b11, 3'd3, 1'b0, 16'h1234, 0, "load_ch0_rl11");
        do_cmd(1'b0, 2'd2, 2'b01, 3'd0, 1'b0, 16'h00AB, 1, "load_ch2_slow");
        chk("load_ch2_slow ce_pulses", 32'(last_cep), 32'd3);
        chk("load_ch2_slow wr_cycles", 32'(last_wr_hi), 32'd8);
        cnt[1] = 16'hBEEF;
        do_cmd(1'b1, 2'd1, 2'b00, 3'd0, 1'b0, 16'h0000, 0, "read_ch1");
        do_cmd(1'b0, 2'd3, 2'b11, 3'd2, 1'b0, 16'h5555, 0, "load_ch3");
        do_cmd(1'b0, 2'd1, 2'b00, 3'd2, 1'b0, 16'h5555, 0, "load_rl00");
        do_cmd(1'b1, 2'd0, 2'b00, 3'd0, 1'b0, 16'h0000, 0, "read_ch0");
        do_cmd(1'b0, 2'd1, 2'b10, 3'd5, 1'b1, 16'hC3A5, 0, "load_ch1_rl10");
        do_cmd(1'b1, 2'd2, 2'b00, 3'd0, 1'b0, 16'h0000, 2, "read_ch2_rand");

        // reset while the MSB write strobe is on the bus
        ce_mode = 0;
        repeat (2) @(negedge clk);
        cmd_op = 1'b0; cmd_ch = 2'd0; cmd_rl = 2'b11; cmd_mode = 3'd2; cmd_bcd = 1'b0;
        cmd_count = 16'hA55A; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("whi wr", 32'(pit_wr), 32'd1);
        chk("whi dout", 32'(pit_dout), 32'hA5);
        #1 reset_n = 1'b0;
        #1;
        chk("abort wr", 32'(pit_wr), 32'd0);
        chk("abort a", 32'(pit_a), 32'd0);
        chk("abort dout", 32'(pit_dout), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        txq.delete();
        @(negedge clk);
        chk("abort ready", 32'(cmd_ready), 32'd1);
        repeat (8) @(negedge clk);
        chk("abort no_strobe", 32'(txq.size()), 32'd0);

        for (int n = 0; n < 40; n++) begin
            for (int c = 0; c < 4; c++) cnt[c] = 16'($urandom);
            do_cmd(1'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   3'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(0, 2)),
                   $sformatf("rnd%0d", n));
        end

        chk("bus_rules", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
